dac_play_buffer: RTL and testbench

- Playback counterpart of the ADC capture double buffer.
- The MCU writes 12-bit samples over the FSMC-style bus into the "fill" half of a ping-pong RAM, then commits it.
- The block streams the "play" half to the DAC, one sample per dac_tick, and swaps halves at the end of each buffer without a gap.
- It sits between the FSMC bridge and the DAC driver, in the system clock domain.

---
 rtl/dac_play_buffer.sv | 192 +++++++++++++++++++
 tb/tb_dac_play_buffer.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_play_buffer.sv
// Ping-pong sample buffer between the FSMC bridge and the DAC driver.
// The MCU fills one half while the other half streams out, one sample per dac_tick.
module dac_play_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int BUF_SIZE   = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dac_tick,
    input  logic                  en,
    input  logic                  state,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [11:0]           dac_data,
    output logic                  dac_valid,
    output logic                  buf_req
);

    localparam int AW = $clog2(BUF_SIZE);
    localparam int LW = AW + 1;

    localparam logic [DATA_WIDTH-1:0] A_BUF    = DATA_WIDTH'(BUF_SIZE);
    localparam logic [DATA_WIDTH-1:0] A_STATUS = DATA_WIDTH'('h4000);
    localparam logic [DATA_WIDTH-1:0] A_LEN    = DATA_WIDTH'('h4001);
    localparam logic [DATA_WIDTH-1:0] A_CTRL   = DATA_WIDTH'('h4002);
    localparam logic [LW-1:0]         L_MAX    = LW'(BUF_SIZE);

    typedef enum logic [1:0] {B_IDLE, B_JUDGE, B_WR, B_RD} bus_state_t;
    typedef enum logic [1:0] {P_IDLE, P_PLAY, P_UNDER} play_state_t;

    logic [11:0] mem [2*BUF_SIZE];

    bus_state_t  b_state, b_next;
    play_state_t p_state, p_next;

    logic                  en_prev, en_rise, en_fall;
    logic [DATA_WIDTH-1:0] addr;
    logic                  fill_buf, committed, run, loop, underrun;
    logic [LW-1:0]         len, play_len;
    logic [AW-1:0]         play_ptr;
    logic [11:0]           play_q;
    logic                  play_v;

    logic do_wr, in_buf, wr_ram, wr_len, wr_ctrl;
    logic commit_now, committed_eff, last;
    logic swap, rd_en, ptr_clr, ptr_inc, set_under;
    logic [DATA_WIDTH-1:0] rd_mux;

    assign en_rise = en & ~en_prev;
    assign en_fall = ~en & en_prev;

    assign do_wr  = (b_state == B_WR) && en_fall && !rst;
    assign in_buf = addr < A_BUF;
    assign wr_ram = do_wr && in_buf && !committed;
    assign wr_len = do_wr && (addr == A_LEN);
    assign wr_ctrl = do_wr && (addr == A_CTRL);

    // A commit landing in the same cycle as a swap decision is honoured at once.
    assign commit_now    = do_wr && (addr == A_STATUS) && rd_data[0] && !committed;
    assign committed_eff = committed | commit_now;

    assign last = ({1'b0, play_ptr} == play_len - LW'(1));

    always_comb begin
        b_next = b_state;
        unique case (b_state)
            B_IDLE:  if (en_rise) b_next = B_JUDGE;
            B_JUDGE: b_next = state ? B_RD : B_WR;
            B_WR:    if (en_fall) b_next = B_IDLE;
            B_RD:    if (!en) b_next = B_IDLE;
            default: b_next = B_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '1;
        if (in_buf)
            rd_mux = DATA_WIDTH'(mem[{fill_buf, addr[AW-1:0]}]);
        else if (addr == A_STATUS)
            rd_mux = DATA_WIDTH'({underrun, p_state == P_PLAY, ~committed});
        else if (addr == A_LEN)
            rd_mux = DATA_WIDTH'(len);
        else if (addr == A_CTRL)
            rd_mux = DATA_WIDTH'({loop, run});
    end

    always_comb begin
        p_next    = p_state;
        swap      = 1'b0;
        rd_en     = 1'b0;
        ptr_clr   = 1'b0;
        ptr_inc   = 1'b0;
        set_under = 1'b0;
        unique case (p_state)
            P_IDLE: begin
                if (run && committed_eff) begin
                    swap   = 1'b1;
                    p_next = P_PLAY;
                end
            end
            P_PLAY: begin
                if (!run) begin
                    p_next  = P_IDLE;
                    ptr_clr = 1'b1;
                end else if (dac_tick) begin
                    rd_en = 1'b1;
                    if (!last) begin
                        ptr_inc = 1'b1;
                    end else if (committed_eff) begin
                        swap = 1'b1;
                    end else if (loop) begin
                        ptr_clr = 1'b1;
                    end else begin
                        set_under = 1'b1;
                        p_next    = P_UNDER;
                    end
                end
            end
            P_UNDER: begin
                if (!run) begin
                    p_next = P_IDLE;
                end else if (committed_eff) begin
                    swap   = 1'b1;
                    p_next = P_PLAY;
                end
            end
            default: p_next = P_IDLE;
        endcase
    end

    // The read of the outgoing half happens before the swap takes effect.
    always_ff @(posedge clk) begin
        if (wr_ram) mem[{fill_buf, addr[AW-1:0]}] <= rd_data[11:0];
        if (rd_en) play_q <= mem[{~fill_buf, play_ptr}];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_state   <= B_IDLE;
            p_state   <= P_IDLE;
            en_prev   <= en;
            addr      <= '0;
            wr_data   <= '0;
            fill_buf  <= 1'b0;
            committed <= 1'b0;
            run       <= 1'b0;
            loop      <= 1'b0;
            underrun  <= 1'b0;
            len       <= L_MAX;
            play_len  <= L_MAX;
            play_ptr  <= '0;
            play_v    <= 1'b0;
            dac_data  <= 12'h800;
            dac_valid <= 1'b0;
            buf_req   <= 1'b0;
        end else begin
            b_state <= b_next;
            p_state <= p_next;
            en_prev <= en;
            if (b_state == B_IDLE && en_rise) addr <= rd_data;
            if (b_state == B_RD) wr_data <= rd_mux;
            if (wr_len)
                len <= (rd_data == '0 || rd_data > A_BUF) ? L_MAX : rd_data[LW-1:0];
            if (wr_ctrl) begin
                run  <= rd_data[0];
                loop <= rd_data[1];
            end
            if (set_under)
                underrun <= 1'b1;
            else if (wr_ctrl && rd_data[2])
                underrun <= 1'b0;
            if (swap)
                committed <= 1'b0;
            else if (commit_now)
                committed <= 1'b1;
            buf_req <= swap;
            if (swap) begin
                fill_buf <= ~fill_buf;
                play_len <= len;
                play_ptr <= '0;
            end else if (ptr_clr) begin
                play_ptr <= '0;
            end else if (ptr_inc) begin
                play_ptr <= play_ptr + AW'(1);
            end
            play_v    <= rd_en;
            dac_valid <= play_v;
            if (play_v) dac_data <= play_q;
        end
    end

endmodule

// File: tb/tb_dac_play_buffer.sv
// Directed bench for dac_play_buffer: bus access, playback, swap, loop, underrun, reset.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_dac_play_buffer;

    logic        clk = 1'b0;
    logic        rst, dac_tick, en, state;
    logic [15:0] rd_data;
    logic [15:0] wr_data;
    logic [11:0] dac_data;
    logic        dac_valid, buf_req;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int brq    = 0;

    logic [11:0] vq[$];
    int          vc[$];
    int          tq[$];

    dac_play_buffer #(.DATA_WIDTH(16), .BUF_SIZE(1024)) dut (
        .clk(clk), .rst(rst), .dac_tick(dac_tick), .en(en), .state(state),
        .rd_data(rd_data), .wr_data(wr_data), .dac_data(dac_data),
        .dac_valid(dac_valid), .buf_req(buf_req)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (dac_valid) begin
            vq.push_back(dac_data);
            vc.push_back(cyc);
        end
        if (buf_req) brq++;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        state = 1'b0; rd_data = a; en = 1'b1;
        step(2);
        rd_data = d;
        step(1);
        en = 1'b0;
        step(2);
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        state = 1'b1; rd_data = a; en = 1'b1;
        step(3);
        d = wr_data;
        en = 1'b0;
        step(2);
        state = 1'b0;
    endtask

    task automatic tick();
        dac_tick = 1'b1;
        tq.push_back(cyc);
        step(1);
        dac_tick = 1'b0;
        step(7);
    endtask

    task automatic clear_logs();
        vq.delete(); vc.delete(); tq.delete();
        brq = 0;
    endtask

    function automatic logic [11:0] vq_at(input int i);
        return (i < vq.size()) ? vq[i] : 12'hEEE;
    endfunction

    function automatic int lat_at(input int i);
        return (i < vc.size() && i < tq.size()) ? vc[i] - tq[i] : -1;
    endfunction

    task automatic test_reset();
        logic [15:0] d;
        rst = 1'b1; en = 1'b0; state = 1'b0; dac_tick = 1'b0; rd_data = '0;
        step(3);
        checks++;
        if (wr_data !== 16'h0000) begin
            errors++; $display("FAIL reset_wr_data: got %h want 0000", wr_data);
        end
        checks++;
        if (dac_data !== 12'h800) begin
            errors++; $display("FAIL reset_dac_data: got %h want 800", dac_data);
        end
        checks++;
        if (dac_valid !== 1'b0) begin
            errors++; $display("FAIL reset_dac_valid: got %b want 0", dac_valid);
        end
        checks++;
        if (buf_req !== 1'b0) begin
            errors++; $display("FAIL reset_buf_req: got %b want 0", buf_req);
        end
        rst = 1'b0;
        step(1);
        bus_read(16'h4000, d);
        checks++;
        if (d !== 16'h0001) begin
            errors++; $display("FAIL reset_status: got %h want 0001", d);
        end
        bus_read(16'h4001, d);
        checks++;
        if (d !== 16'h0400) begin
            errors++; $display("FAIL reset_len: got %h want 0400", d);
        end
        bus_read(16'h4002, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++; $display("FAIL reset_ctrl: got %h want 0000", d);
        end
    endtask

    task automatic test_play_underrun();
        logic [15:0] d;
        for (int i = 0; i < 4; i++) bus_write(16'(i), 16'((i + 1) << 8));
        bus_write(16'h4001, 16'd4);
        bus_write(16'h4000, 16'h0001);
        bus_read(16'h4000, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++; $display("FAIL commit_status: got %h want 0000", d);
        end
        clear_logs();
        bus_write(16'h4002, 16'h0001);
        step(2);
        checks++;
        if (brq !== 1) begin
            errors++; $display("FAIL start_buf_req: got %0d pulses want 1", brq);
        end
        tick(); tick();
        bus_read(16'h4000, d);
        checks++;
        if (d !== 16'h0003) begin
            errors++; $display("FAIL playing_status: got %h want 0003", d);
        end
        tick(); tick(); tick(); tick();
        checks++;
        if (vq.size() != 4) begin
            errors++; $display("FAIL play_count: got %0d samples want 4", vq.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (vq_at(i) !== 12'((i + 1) << 8)) begin
                errors++;
                $display("FAIL play_sample%0d: got %h want %h", i, vq_at(i), 12'((i + 1) << 8));
            end
            checks++;
            if (lat_at(i) != 2) begin
                errors++; $display("FAIL play_latency%0d: got %0d want 2", i, lat_at(i));
            end
        end
        bus_read(16'h4000, d);
        checks++;
        if (d !== 16'h0005) begin
            errors++; $display("FAIL underrun_status: got %h want 0005", d);
        end
        checks++;
        if (dac_data !== 12'h400) begin
            errors++; $display("FAIL underrun_hold: got %h want 400", dac_data);
        end
    endtask

    task automatic test_gapless_swap();
        logic [15:0] d;
        bus_write(16'h4002, 16'h0004);
        for (int i = 0; i < 4; i++) bus_write(16'(i), 16'((i + 1) << 8));
        bus_write(16'h4001, 16'd4);
        bus_write(16'h4000, 16'h0001);
        clear_logs();
        bus_write(16'h4002, 16'h0001);
        for (int i = 0; i < 4; i++) bus_write(16'(i), 16'(16'hA00 + i));
        tick(); tick();
        bus_write(16'h4000, 16'h0001);
        bus_read(16'h4000, d);
        checks++;
        if (d !== 16'h0002) begin
            errors++; $display("FAIL gapless_committed_status: got %h want 0002", d);
        end
        repeat (4) tick();
        checks++;
        if (vq.size() != 6) begin
            errors++; $display("FAIL gapless_count: got %0d samples want 6", vq.size());
        end
        checks++;
        if (vq_at(3) !== 12'h400) begin
            errors++; $display("FAIL gapless_last_old: got %h want 400", vq_at(3));
        end
        checks++;
        if (vq_at(4) !== 12'hA00) begin
            errors++; $display("FAIL gapless_first_new: got %h want A00", vq_at(4));
        end
        checks++;
        if (vq_at(5) !== 12'hA01) begin
            errors++; $display("FAIL gapless_second_new: got %h want A01", vq_at(5));
        end
        checks++;
        if (lat_at(4) != 2) begin
            errors++; $display("FAIL gapless_latency: got %0d want 2", lat_at(4));
        end
        checks++;
        if (brq !== 2) begin
            errors++; $display("FAIL gapless_buf_req: got %0d pulses want 2", brq);
        end
        bus_read(16'h4000, d);
        checks++;
        if (d !== 16'h0003) begin
            errors++; $display("FAIL gapless_status_after: got %h want 0003", d);
        end
    endtask

    task automatic test_same_cycle_commit();
        logic [15:0] d;
        bus_write(16'h4002, 16'h0004);
        bus_write(16'h0000, 16'h0301);
        bus_write(16'h0001, 16'h0302);
        bus_write(16'h4001, 16'd2);
        bus_write(16'h4000, 16'h0001);
        clear_logs();
        bus_write(16'h4002, 16'h0001);
        tick();
        state = 1'b0; rd_data = 16'h4000; en = 1'b1;
        step(2);
        rd_data = 16'h0001;
        step(1);
        en = 1'b0;
        dac_tick = 1'b1;
        tq.push_back(cyc);
        step(1);
        dac_tick = 1'b0;
        step(7);
        tick();
        checks++;
        if (vq.size() != 3) begin
            errors++; $display("FAIL samecyc_count: got %0d samples want 3", vq.size());
        end
        checks++;
        if (vq_at(1) !== 12'h302) begin
            errors++; $display("FAIL samecyc_last_old: got %h want 302", vq_at(1));
        end
        checks++;
        if (vq_at(2) !== 12'hA00) begin
            errors++; $display("FAIL samecyc_first_new: got %h want A00", vq_at(2));
        end
        checks++;
        if (brq !== 2) begin
            errors++; $display("FAIL samecyc_buf_req: got %0d pulses want 2", brq);
        end
        bus_read(16'h4000, d);
        checks++;
        if (d !== 16'h0003) begin
            errors++; $display("FAIL samecyc_status: got %h want 0003", d);
        end
    endtask

    task automatic test_loop();
        logic [15:0] d;
        logic [11:0] exp_s [5];
        exp_s = '{12'h111, 12'h222, 12'h111, 12'h222, 12'h111};
        bus_write(16'h4002, 16'h0004);
        bus_write(16'h0000, 16'h0111);
        bus_write(16'h0001, 16'h0222);
        bus_write(16'h4001, 16'd2);
        bus_write(16'h4000, 16'h0001);
        clear_logs();
        bus_write(16'h4002, 16'h0003);
        repeat (5) tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (vq_at(i) !== exp_s[i]) begin
                errors++; $display("FAIL loop_sample%0d: got %h want %h", i, vq_at(i), exp_s[i]);
            end
        end
        bus_read(16'h4000, d);
        checks++;
        if (d !== 16'h0003) begin
            errors++; $display("FAIL loop_status: got %h want 0003", d);
        end
        checks++;
        if (brq !== 1) begin
            errors++; $display("FAIL loop_buf_req: got %0d pulses want 1", brq);
        end
    endtask

    task automatic test_commit_protect();
        logic [15:0] d;
        bus_write(16'h4002, 16'h0004);
        bus_write(16'h0000, 16'h05A5);
        bus_read(16'h0000, d);
        checks++;
        if (d !== 16'h05A5) begin
            errors++; $display("FAIL ram_readback: got %h want 05A5", d);
        end
        bus_write(16'h4000, 16'h0001);
        bus_write(16'h0000, 16'h0777);
        bus_read(16'h0000, d);
        checks++;
        if (d !== 16'h05A5) begin
            errors++; $display("FAIL committed_write_blocked: got %h want 05A5", d);
        end
        bus_read(16'h5000, d);
        checks++;
        if (d !== 16'hFFFF) begin
            errors++; $display("FAIL unmapped_5000: got %h want FFFF", d);
        end
        bus_read(16'h2000, d);
        checks++;
        if (d !== 16'hFFFF) begin
            errors++; $display("FAIL beyond_buf_2000: got %h want FFFF", d);
        end
        bus_write(16'h4001, 16'h0000);
        bus_read(16'h4001, d);
        checks++;
        if (d !== 16'h0400) begin
            errors++; $display("FAIL len_zero: got %h want 0400", d);
        end
        bus_write(16'h4001, 16'h0800);
        bus_read(16'h4001, d);
        checks++;
        if (d !== 16'h0400) begin
            errors++; $display("FAIL len_too_big: got %h want 0400", d);
        end
        bus_write(16'h4001, 16'h0002);
        bus_read(16'h4001, d);
        checks++;
        if (d !== 16'h0002) begin
            errors++; $display("FAIL len_two: got %h want 0002", d);
        end
        bus_read(16'h4000, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++; $display("FAIL idle_committed_status: got %h want 0000", d);
        end
    endtask

    task automatic test_reset_abort();
        logic [15:0] d;
        bus_read(16'h5000, d);
        bus_write(16'h4002, 16'h0001);
        clear_logs();
        tick();
        dac_tick = 1'b1;
        step(1);
        dac_tick = 1'b0;
        rst = 1'b1;
        step(1);
        checks++;
        if (dac_valid !== 1'b0) begin
            errors++; $display("FAIL rst_play_valid: got %b want 0", dac_valid);
        end
        checks++;
        if (dac_data !== 12'h800) begin
            errors++; $display("FAIL rst_play_data: got %h want 800", dac_data);
        end
        checks++;
        if (wr_data !== 16'h0000) begin
            errors++; $display("FAIL rst_play_wr_data: got %h want 0000", wr_data);
        end
        step(1);
        rst = 1'b0;
        step(2);
        checks++;
        if (vq.size() != 1 || vq_at(0) !== 12'h5A5) begin
            errors++;
            $display("FAIL rst_play_samples: got %0d samples first %h want 1 sample 5A5",
                     vq.size(), vq_at(0));
        end
        state = 1'b0; rd_data = 16'h0002; en = 1'b1;
        step(2);
        rd_data = 16'h0999;
        step(1);
        en = 1'b0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
        bus_read(16'h0002, d);
        checks++;
        if (d !== 16'h0A02) begin
            errors++; $display("FAIL rst_aborted_write: got %h want 0A02", d);
        end
        bus_read(16'h0000, d);
        checks++;
        if (d !== 16'h05A5) begin
            errors++; $display("FAIL rst_ram_kept: got %h want 05A5", d);
        end
        bus_read(16'h4000, d);
        checks++;
        if (d !== 16'h0001) begin
            errors++; $display("FAIL rst_status_after: got %h want 0001", d);
        end
        bus_read(16'h4001, d);
        checks++;
        if (d !== 16'h0400) begin
            errors++; $display("FAIL rst_len_after: got %h want 0400", d);
        end
    endtask

    initial begin
        test_reset();
        test_play_underrun();
        test_gapless_swap();
        test_same_cycle_commit();
        test_loop();
        test_commit_protect();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
